// File: rtl/ras_stack_pkg.sv
// Fetch package: RAS control encodings shared with the branch decoders, branch kinds, default RAS depth.
// Pure declarations; no logic, no latency, no backpressure.
package ras_stack_pkg;

  localparam int RAS_DEPTH = 8;

  // Control driven by the selected fetch-1 decoder into the return address stack
  typedef enum logic [1:0] {
    RAS_CTL_NONE    = 2'b00,
    RAS_CTL_PUSH    = 2'b01,
    RAS_CTL_POP     = 2'b10,
    RAS_CTL_POPPUSH = 2'b11
  } ras_ctl_e;

  typedef enum logic [1:0] {
    BR_COND      = 2'b00,
    BR_UNCOND    = 2'b01,
    BR_INDIR_PC  = 2'b10,
    BR_INDIR_RAS = 2'b11
  } br_type_e;

endpackage

// File: rtl/ras_mem.sv
// RAS entry array: DEPTH x AW registers, one write port, one async read port, sync reset.
// Write lands on the clock edge; read is combinational; no backpressure.
module ras_mem #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int AW    = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_idx,
  input  logic [AW-1:0]    wr_dat,
  input  logic [PTR_W-1:0] rd_idx,
  output logic [AW-1:0]    rd_dat
);

  logic [AW-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/ras_stack.sv
// Return address stack for fetch-1 decoders, circular with checkpoint/recover; RAS_REPAIR_DATA_EN also repairs the TOS entry.
// TOS read is combinational; updates visible one edge later; stall_i is the only throttle, no handshake.
module ras_stack
  import ras_stack_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int AW    = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ctl_vld_i,
  input  logic [1:0]       ras_ctl_i,
  input  logic [AW-1:0]    push_addr_i,
  input  logic             stall_i,
  input  logic             recover_i,
  input  logic [PTR_W-1:0] recover_tos_i,
  input  logic [PTR_W:0]   recover_cnt_i,
  input  logic [AW-1:0]    recover_data_i,
  output logic [AW-1:0]    ras_data_o,
  output logic             ras_valid_o,
  output logic [PTR_W-1:0] chkpt_tos_o,
  output logic [PTR_W:0]   chkpt_cnt_o,
  output logic [AW-1:0]    chkpt_data_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int CW = PTR_W + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [PTR_W-1:0] tos_q, tos_d, tos_inc, tos_dec;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             upd, empty, full, do_push;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [AW-1:0]    wr_dat, rd_dat;

  assign upd     = ctl_vld_i & ~stall_i & ~recover_i;
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_FULL);
  assign tos_inc = tos_q + PTR_W'(1);
  assign tos_dec = tos_q - PTR_W'(1);

  always_comb begin
    tos_d   = tos_q;
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = tos_inc;
    wr_dat  = push_addr_i;
    do_push = 1'b0;
    if (recover_i) begin
      tos_d = recover_tos_i;
      cnt_d = (recover_cnt_i > CNT_FULL) ? CNT_FULL : recover_cnt_i;
`ifdef RAS_REPAIR_DATA_EN
      wr_en  = 1'b1;
      wr_idx = recover_tos_i;
      wr_dat = recover_data_i;
`endif
    end else if (upd) begin
      case (ras_ctl_i)
        RAS_CTL_PUSH: do_push = 1'b1;
        RAS_CTL_POP: begin
          if (empty) begin
            unf_d = 1'b1;
          end else begin
            tos_d = tos_dec;
            cnt_d = cnt_q - CW'(1);
          end
        end
        RAS_CTL_POPPUSH: begin
          // Empty stack has no entry to replace, so this degrades to a plain push
          if (empty) begin
            do_push = 1'b1;
          end else begin
            wr_en  = 1'b1;
            wr_idx = tos_q;
          end
        end
        default: ;
      endcase
      if (do_push) begin
        wr_en  = 1'b1;
        wr_idx = tos_inc;
        tos_d  = tos_inc;
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tos_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  ras_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .AW    (AW)
  ) u_mem (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .wr_en  (wr_en),
    .wr_idx (wr_idx),
    .wr_dat (wr_dat),
    .rd_idx (tos_q),
    .rd_dat (rd_dat)
  );

  assign ras_data_o  = empty ? '0 : rd_dat;
  assign ras_valid_o = ~empty;
  assign chkpt_tos_o = tos_q;
  assign chkpt_cnt_o = cnt_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

`ifdef RAS_REPAIR_DATA_EN
  assign chkpt_data_o = ras_data_o;
`else
  // Without data repair the checkpoint carries no entry and recover data has no sink
  logic unused_recover_data;
  assign unused_recover_data = ^recover_data_i;
  assign chkpt_data_o = '0;
`endif

endmodule

// File: tb/tb_ras_stack.sv
// Directed self-checking bench for ras_stack (DEPTH=8, AW=64); expectations hand-computed.
module tb_ras_stack;
  import ras_stack_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctl_vld;
  logic [1:0]  ras_ctl;
  logic [63:0] push_addr;
  logic        stall;
  logic        recover;
  logic [2:0]  recover_tos;
  logic [3:0]  recover_cnt;
  logic [63:0] recover_data;
  logic [63:0] ras_data;
  logic        ras_valid;
  logic [2:0]  chkpt_tos;
  logic [3:0]  chkpt_cnt;
  logic [63:0] chkpt_data;
  logic        overflow;
  logic        underflow;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ras_stack #(.DEPTH(8), .AW(64)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ctl_vld_i      (ctl_vld),
    .ras_ctl_i      (ras_ctl),
    .push_addr_i    (push_addr),
    .stall_i        (stall),
    .recover_i      (recover),
    .recover_tos_i  (recover_tos),
    .recover_cnt_i  (recover_cnt),
    .recover_data_i (recover_data),
    .ras_data_o     (ras_data),
    .ras_valid_o    (ras_valid),
    .chkpt_tos_o    (chkpt_tos),
    .chkpt_cnt_o    (chkpt_cnt),
    .chkpt_data_o   (chkpt_data),
    .overflow_o     (overflow),
    .underflow_o    (underflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [1:0] ctl, input logic [63:0] addr);
    ctl_vld   = 1'b1;
    ras_ctl   = ctl;
    push_addr = addr;
    tick();
    ctl_vld   = 1'b0;
    ras_ctl   = RAS_CTL_NONE;
  endtask

  task automatic do_recover(input logic [2:0] t, input logic [3:0] c, input logic [63:0] d);
    recover      = 1'b1;
    recover_tos  = t;
    recover_cnt  = c;
    recover_data = d;
    tick();
    recover      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ctl_vld = 1'b0; ras_ctl = RAS_CTL_NONE; push_addr = '0;
    stall = 1'b0; recover = 1'b0; recover_tos = '0; recover_cnt = '0; recover_data = '0;

    // Reset state
    do_reset();
    tick();
    check("rst_data", ras_data, 64'h0);
    check("rst_valid", {63'b0, ras_valid}, 64'h0);
    check("rst_tos", {61'b0, chkpt_tos}, 64'h0);
    check("rst_cnt", {60'b0, chkpt_cnt}, 64'h0);
    check("rst_chkdata", chkpt_data, 64'h0);
    check("rst_ovf", {63'b0, overflow}, 64'h0);
    check("rst_unf", {63'b0, underflow}, 64'h0);

    // Basic push/push/pop
    op(RAS_CTL_PUSH, 64'h1004);
    op(RAS_CTL_PUSH, 64'h2008);
    check("pp_data", ras_data, 64'h2008);
    check("pp_cnt", {60'b0, chkpt_cnt}, 64'd2);
    check("pp_tos", {61'b0, chkpt_tos}, 64'd2);
    op(RAS_CTL_POP, 64'h0);
    check("pop_data", ras_data, 64'h1004);
    check("pop_cnt", {60'b0, chkpt_cnt}, 64'd1);
    op(RAS_CTL_POP, 64'h0);
    check("pop2_valid", {63'b0, ras_valid}, 64'h0);
    check("pop2_data", ras_data, 64'h0);

    // Overflow with wrap, then drain and underflow
    for (int k = 0; k < 8; k++) op(RAS_CTL_PUSH, 64'h100 + 64'(4 * k));
    check("fill_cnt", {60'b0, chkpt_cnt}, 64'd8);
    check("fill_noovf", {63'b0, overflow}, 64'h0);
    op(RAS_CTL_PUSH, 64'h120);
    check("ovf_pulse", {63'b0, overflow}, 64'h1);
    check("ovf_cnt", {60'b0, chkpt_cnt}, 64'd8);
    check("ovf_data", ras_data, 64'h120);
    check("ovf_tos_wrap", {61'b0, chkpt_tos}, 64'd1);
    tick();
    check("ovf_clear", {63'b0, overflow}, 64'h0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_%0d", i), ras_data, 64'h120 - 64'(4 * i));
      op(RAS_CTL_POP, 64'h0);
    end
    check("drain_cnt", {60'b0, chkpt_cnt}, 64'd0);
    check("drain_nounf", {63'b0, underflow}, 64'h0);
    op(RAS_CTL_POP, 64'h0);
    check("unf_pulse", {63'b0, underflow}, 64'h1);
    check("unf_data", ras_data, 64'h0);
    check("unf_cnt", {60'b0, chkpt_cnt}, 64'd0);
    check("unf_tos", {61'b0, chkpt_tos}, 64'd1);
    tick();
    check("unf_clear", {63'b0, underflow}, 64'h0);

    // Pop+push on empty acts as push; on non-empty replaces TOS
    op(RAS_CTL_POPPUSH, 64'h3000);
    check("pp0_cnt", {60'b0, chkpt_cnt}, 64'd1);
    check("pp0_data", ras_data, 64'h3000);
    check("pp0_nounf", {63'b0, underflow}, 64'h0);
    op(RAS_CTL_POPPUSH, 64'h4000);
    check("pp1_cnt", {60'b0, chkpt_cnt}, 64'd1);
    check("pp1_data", ras_data, 64'h4000);

    // Checkpoint and recover
    do_reset();
    op(RAS_CTL_PUSH, 64'hA0);
    check("ck_tos", {61'b0, chkpt_tos}, 64'd1);
    check("ck_cnt", {60'b0, chkpt_cnt}, 64'd1);
`ifdef RAS_REPAIR_DATA_EN
    check("ck_data", chkpt_data, 64'hA0);
`else
    check("ck_data", chkpt_data, 64'h0);
`endif
    op(RAS_CTL_PUSH, 64'hB0);
    op(RAS_CTL_PUSH, 64'hC0);
    check("ck_pre_data", ras_data, 64'hC0);
    do_recover(3'd1, 4'd1, 64'hA0);
    check("rec_data", ras_data, 64'hA0);
    check("rec_cnt", {60'b0, chkpt_cnt}, 64'd1);

    // Recover wins over a concurrent push
    ctl_vld = 1'b1; ras_ctl = RAS_CTL_PUSH; push_addr = 64'hEE;
    do_recover(3'd1, 4'd1, 64'hA0);
    ctl_vld = 1'b0; ras_ctl = RAS_CTL_NONE;
    check("recpush_data", ras_data, 64'hA0);
    check("recpush_cnt", {60'b0, chkpt_cnt}, 64'd1);
    check("recpush_tos", {61'b0, chkpt_tos}, 64'd1);

    // Stall blocks the update
    stall = 1'b1;
    op(RAS_CTL_PUSH, 64'hFF);
    stall = 1'b0;
    check("stall_data", ras_data, 64'hA0);
    check("stall_cnt", {60'b0, chkpt_cnt}, 64'd1);

    // Over-range recover count clamps to DEPTH
    do_recover(3'd1, 4'd12, 64'hA0);
    check("clamp_cnt", {60'b0, chkpt_cnt}, 64'd8);
    do_recover(3'd1, 4'd1, 64'hA0);
    check("unclamp_cnt", {60'b0, chkpt_cnt}, 64'd1);

    // Wrong-path pop+push clobbers TOS, then recover
    op(RAS_CTL_POPPUSH, 64'hDD);
    check("clob_data", ras_data, 64'hDD);
    do_recover(3'd1, 4'd1, 64'hA0);
`ifdef RAS_REPAIR_DATA_EN
    check("repair_data", ras_data, 64'hA0);
`else
    check("repair_data", ras_data, 64'hDD);
`endif
    check("repair_cnt", {60'b0, chkpt_cnt}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ras_stack.md
Name: ras_stack

Overview:
- Return address stack that feeds the fetch-1 branch decoders.
- Supplies the predicted return target (top of stack) that decoders use for RET/JSR_COROUTINE.
- Consumes the selected decoder's 2-bit RAS control and the return address to push.
- Circular buffer with pointer/count checkpoint and recovery, so mispredicted paths can be repaired from execute.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- PTR_W, 3, log2(DEPTH); derived, not overridden independently.
- AW, 64, address width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- ctl_vld_i  in  1  ras_ctl_i/push_addr_i valid this cycle (selected fetch-1 branch)
- ras_ctl_i  in  2  00 none, 01 push, 10 pop, 11 pop+push
- push_addr_i  in  AW  return address (branch PC + 4)
- stall_i  in  1  fetch stall; blocks speculative updates
- recover_i  in  1  mispredict repair strobe from execute
- recover_tos_i  in  PTR_W  checkpointed top-of-stack pointer
- recover_cnt_i  in  PTR_W+1  checkpointed occupancy
- recover_data_i  in  AW  checkpointed TOS entry (used only with RAS_REPAIR_DATA_EN)
- ras_data_o  out  AW  current TOS entry; 0 when empty
- ras_valid_o  out  1  occupancy > 0
- chkpt_tos_o  out  PTR_W  current tos, before this cycle's update
- chkpt_cnt_o  out  PTR_W+1  current occupancy, before this cycle's update
- chkpt_data_o  out  AW  current TOS entry, for the checkpoint
- overflow_o  out  1  one-cycle pulse when a push overwrites the oldest entry
- underflow_o  out  1  one-cycle pulse on a pop while empty

Behaviour:
- State: mem[DEPTH], tos (PTR_W), cnt (0..DEPTH).
- Reset: all mem=0, tos=0, cnt=0; every output reads 0 the cycle after reset.
- Read path:
  - ras_data_o = mem[tos] when cnt>0, else 0.
  - Combinational from registered state, so decoders see it in the same cycle.
  - Updates become visible the cycle after the edge.
- Update enable: upd = ctl_vld_i & ~stall_i & ~recover_i.
- Priority: rst_i > recover_i > upd.
- Push (01):
  - tos <= tos+1 modulo DEPTH; mem[tos+1] <= push_addr_i.
  - cnt saturates at DEPTH.
  - If cnt==DEPTH before the push, pulse overflow_o; the oldest entry is silently lost.
- Pop (10):
  - If cnt>0: tos <= tos-1 modulo DEPTH, cnt <= cnt-1.
  - If cnt==0: no state change, pulse underflow_o.
- Pop+push (11):
  - If cnt>0: mem[tos] <= push_addr_i; tos and cnt unchanged.
  - If cnt==0: behaves exactly as a push (cnt becomes 1, no underflow_o).
- None (00), or upd=0: state held.
- Recover: tos <= recover_tos_i and cnt <= recover_cnt_i in one cycle; any concurrent ctl is dropped. recover_cnt_i > DEPTH is clamped to DEPTH.
- Checkpoint outputs reflect pre-edge state; the decoder attaches them to the branch in the same cycle.
- Pulses: overflow_o and underflow_o are registered, high exactly one cycle after the causing edge, and cleared by reset or recover.
- Pointer wrap: tos DEPTH-1 -> 0 on push and 0 -> DEPTH-1 on pop, wrapping in PTR_W bits.
- No pipeline latency beyond one edge; no handshake backpressure (stall_i is the only throttle).

Optional Feature:
- Macro: RAS_REPAIR_DATA_EN.
- Defined: on recover_i, additionally mem[recover_tos_i] <= recover_data_i. This repairs a TOS entry clobbered by a wrong-path push or pop+push.
- Undefined: recover restores pointer and count only; recover_data_i is ignored; chkpt_data_o is tied to 0.

Decomposition:
- Shared fetch package holds:
  - RAS_CTL_NONE/PUSH/POP/POPPUSH (2'b00/01/10/11), shared with the branch decoders.
  - BR_COND/BR_UNCOND/BR_INDIR_PC/BR_INDIR_RAS.
  - Default RAS_DEPTH.
- One sub-module, ras_mem: DEPTH x AW register array with one write port, one async read port and synchronous reset. Pointer/count logic stays in ras_stack.

Test Plan:
- Reset then push 0x1004, 0x2008 -> ras_data_o=0x2008, cnt=2; pop -> ras_data_o=0x1004, cnt=1.
- Nine pushes of 0x100+4k (k=0..8) with DEPTH=8 -> overflow_o pulses once (9th push), cnt=8, ras_data_o=0x120; eight pops return 0x120..0x104; the ninth pop gives underflow_o and ras_data_o=0.
- cnt=0, pop+push 0x3000 -> cnt=1, ras_data_o=0x3000, no underflow_o; then pop+push 0x4000 -> cnt=1, ras_data_o=0x4000.
- Push 0xA0, capture checkpoint (tos=1, cnt=1); push 0xB0, push 0xC0; recover_i with tos=1, cnt=1 -> ras_data_o=0xA0, cnt=1.
- Same cycle: recover_i=1 plus ctl_vld_i with push -> only recover takes effect; stall_i=1 with push -> state unchanged.
- RAS_REPAIR_DATA_EN: checkpoint TOS=0xA0; pop+push 0xDD; recover with data 0xA0 -> ras_data_o=0xA0 (without the macro it reads 0xDD).
